// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter between the instruction cache (read-only) and the
// write-through data cache. Each granted request is registered and held on the
// m_* port until m_ready. The requester then gets a registered one-cycle ready
// together with the captured read data. The data side wins ties, but a
// bounded-starvation counter forces an instruction grant after MAX_D_BURST
// consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned A_WIDTH     = 32,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  // Instruction cache side
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  output logic [31:0]        i_dout,
  output logic               i_ready,
  // Data cache side
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_din,
  input  logic [3:0]         d_wen,
  input  logic [1:0]         d_size,
  input  logic               d_rw,
  input  logic               d_strobe,
  output logic [31:0]        d_dout,
  output logic               d_ready,
  // Shared memory port
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  output logic               m_rw,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] MaxBurst = 4'(MAX_D_BURST);

  logic [1:0]         state_q, state_d;
  logic               gnt_q, gnt_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [A_WIDTH-1:0] m_a_q, m_a_d;
  logic [31:0]        m_din_q, m_din_d;
  logic [3:0]         m_wen_q, m_wen_d;
  logic [1:0]         m_size_q, m_size_d;
  logic               m_rw_q, m_rw_d;
  logic               m_strobe_q, m_strobe_d;
  logic [31:0]        i_dout_q, i_dout_d;
  logic [31:0]        d_dout_q, d_dout_d;
  logic               i_ready_q, i_ready_d;
  logic               d_ready_q, d_ready_d;

  logic grant_i, grant_d;

  // Arbitration: D wins ties unless I has already waited out a full D burst.
  always_comb begin
    grant_i = i_strobe && (!d_strobe || (wait_cnt_q == MaxBurst));
    grant_d = d_strobe && !grant_i;
  end

  // Next-state logic for the sequencer, the latched request and the responses.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    wait_cnt_d = wait_cnt_q;
    m_a_d      = m_a_q;
    m_din_d    = m_din_q;
    m_wen_d    = m_wen_q;
    m_size_d   = m_size_q;
    m_rw_d     = m_rw_q;
    m_strobe_d = m_strobe_q;
    i_dout_d   = i_dout_q;
    d_dout_d   = d_dout_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // I no longer waiting: its starvation history is void.
        if (!i_strobe) begin
          wait_cnt_d = 4'd0;
        end
        if (grant_i) begin
          gnt_d      = 1'b0;
          m_a_d      = i_a;
          m_din_d    = 32'd0;
          m_wen_d    = 4'b1111;
          m_size_d   = 2'b10;
          m_rw_d     = 1'b0;
          m_strobe_d = 1'b1;
          wait_cnt_d = 4'd0;
          state_d    = StBusy;
        end else if (grant_d) begin
          gnt_d      = 1'b1;
          m_a_d      = d_a;
          m_din_d    = d_din;
          m_wen_d    = d_wen;
          m_size_d   = d_size;
          m_rw_d     = d_rw;
          m_strobe_d = 1'b1;
          state_d    = StBusy;
          if (i_strobe && (wait_cnt_q < MaxBurst)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      StBusy: begin
        if (m_ready) begin
          if (gnt_q) begin
            d_dout_d  = m_dout;
            d_ready_d = 1'b1;
          end else begin
            i_dout_d  = m_dout;
            i_ready_d = 1'b1;
          end
          m_strobe_d = 1'b0;
          state_d    = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset abandons any in-flight request without a ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      wait_cnt_q <= 4'd0;
      m_a_q      <= '0;
      m_din_q    <= 32'd0;
      m_wen_q    <= 4'd0;
      m_size_q   <= 2'd0;
      m_rw_q     <= 1'b0;
      m_strobe_q <= 1'b0;
      i_dout_q   <= 32'd0;
      d_dout_q   <= 32'd0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      wait_cnt_q <= wait_cnt_d;
      m_a_q      <= m_a_d;
      m_din_q    <= m_din_d;
      m_wen_q    <= m_wen_d;
      m_size_q   <= m_size_d;
      m_rw_q     <= m_rw_d;
      m_strobe_q <= m_strobe_d;
      i_dout_q   <= i_dout_d;
      d_dout_q   <= d_dout_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  assign m_a      = m_a_q;
  assign m_din    = m_din_q;
  assign m_wen    = m_wen_q;
  assign m_size   = m_size_q;
  assign m_rw     = m_rw_q;
  assign m_strobe = m_strobe_q;
  assign i_dout   = i_dout_q;
  assign d_dout   = d_dout_q;
  assign i_ready  = i_ready_q;
  assign d_ready  = d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_a, d_a, m_a;
  logic          i_strobe, d_strobe, d_rw, m_rw, m_strobe, m_ready;
  logic [31:0]   i_dout, d_dout, d_din, m_din, m_dout;
  logic          i_ready, d_ready;
  logic [3:0]    d_wen, m_wen;
  logic [1:0]    d_size, m_size;

  mem_port_arbiter #(
    .A_WIDTH    (AW),
    .MAX_D_BURST(MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_a     (i_a),
    .i_strobe(i_strobe),
    .i_dout  (i_dout),
    .i_ready (i_ready),
    .d_a     (d_a),
    .d_din   (d_din),
    .d_wen   (d_wen),
    .d_size  (d_size),
    .d_rw    (d_rw),
    .d_strobe(d_strobe),
    .d_dout  (d_dout),
    .d_ready (d_ready),
    .m_a     (m_a),
    .m_din   (m_din),
    .m_wen   (m_wen),
    .m_size  (m_size),
    .m_rw    (m_rw),
    .m_strobe(m_strobe),
    .m_dout  (m_dout),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: D grants made while I waits, plus the last data each side received.
  int          mdl_cnt;
  logic [31:0] mdl_i_dout, mdl_d_dout;

  // Observations from the last transaction (taken from the DUT outputs).
  int          obs_gnt;  // 0 = I ready seen, 1 = D ready seen, 2 = no grant, 3 = no ready
  int          exp_gnt;  // model's winner, same encoding
  logic [31:0] obs_a, obs_din, obs_dout;
  logic [3:0]  obs_wen;
  logic [1:0]  obs_size;
  logic        obs_rw;

  typedef struct {
    logic        is_d;
    logic [31:0] a, din;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic        rw;
    int          lat;
    logic [31:0] rdata;
    int          e_gnt;
    logic [31:0] e_a, e_din;
    logic [3:0]  e_wen;
    logic [1:0]  e_size;
    logic        e_rw;
  } vec_t;

  vec_t vecs[4];
  int   seq[10];
  int   exp_seq[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_m_a"}, m_a, 32'd0);
    chk({tag, "_m_din"}, m_din, 32'd0);
    chk({tag, "_m_wen"}, {28'd0, m_wen}, 32'd0);
    chk({tag, "_m_size"}, {30'd0, m_size}, 32'd0);
    chk({tag, "_m_rw"}, {31'd0, m_rw}, 32'd0);
    chk({tag, "_m_strobe"}, {31'd0, m_strobe}, 32'd0);
    chk({tag, "_i_ready"}, {31'd0, i_ready}, 32'd0);
    chk({tag, "_d_ready"}, {31'd0, d_ready}, 32'd0);
    chk({tag, "_i_dout"}, i_dout, 32'd0);
    chk({tag, "_d_dout"}, d_dout, 32'd0);
  endtask

  // One arbitration cycle plus, if anything was granted, the whole transaction.
  // Inputs must be set for the coming IDLE edge. Returns after the RESP cycle.
  task automatic run_txn(input int lat, input logic [31:0] rdata);
    logic        any, win_d;
    logic [31:0] ea, edin;
    logic [3:0]  ewen;
    logic [1:0]  esz;
    logic        erw;
    any = i_strobe | d_strobe;
    // Spec rules: D preferred, I forced after MAX D grants while it waits.
    if (!i_strobe) mdl_cnt = 0;
    win_d = d_strobe && !(i_strobe && mdl_cnt == MAX);
    if (any && !win_d) mdl_cnt = 0;
    else if (win_d && i_strobe && mdl_cnt < MAX) mdl_cnt++;
    if (win_d) begin
      ea = d_a; edin = d_din; ewen = d_wen; esz = d_size; erw = d_rw;
    end else begin
      ea = i_a; edin = 32'd0; ewen = 4'hf; esz = 2'b10; erw = 1'b0;
    end
    exp_gnt = !any ? 2 : (win_d ? 1 : 0);
    m_ready = 1'($urandom % 2);  // ignored in IDLE
    m_dout  = $urandom;
    @(posedge clk); #1;
    if (!any) begin
      obs_gnt = 2;
      chk("idle_no_strobe", {31'd0, m_strobe}, 32'd0);
      chk("idle_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
      m_ready = 1'b0;
      return;
    end
    obs_a = m_a; obs_din = m_din; obs_wen = m_wen; obs_size = m_size; obs_rw = m_rw;
    chk("grant_strobe", {31'd0, m_strobe}, 32'd1);
    chk("grant_m_a", m_a, ea);
    chk("grant_m_fields", {m_din, m_wen, m_size, m_rw}, {edin, ewen, esz, erw});
    m_ready = (lat == 0);
    m_dout  = (lat == 0) ? rdata : $urandom;
    for (int c = 0; c < lat; c++) begin
      @(posedge clk); #1;
      chk("busy_stable", {m_a, m_din, m_wen, m_size, m_rw, m_strobe}, {ea, edin, ewen, esz, erw, 1'b1});
      chk("busy_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
      m_ready = (c == lat - 1);
      m_dout  = m_ready ? rdata : $urandom;
    end
    @(posedge clk); #1;
    obs_gnt  = d_ready ? 1 : (i_ready ? 0 : 3);
    obs_dout = win_d ? d_dout : i_dout;
    chk("resp_ready", {30'd0, i_ready, d_ready}, win_d ? 32'd1 : 32'd2);
    chk("resp_dout", obs_dout, rdata);
    chk("resp_other_dout", win_d ? i_dout : d_dout, win_d ? mdl_i_dout : mdl_d_dout);
    chk("resp_strobe_low", {31'd0, m_strobe}, 32'd0);
    if (win_d) mdl_d_dout = rdata;
    else mdl_i_dout = rdata;
    m_ready = 1'($urandom % 2);  // ignored in RESP
    m_dout  = $urandom;
    @(posedge clk); #1;
    chk("post_resp_ready_low", {30'd0, i_ready, d_ready}, 32'd0);
    chk("post_resp_strobe_low", {31'd0, m_strobe}, 32'd0);
    m_ready = 1'b0;
  endtask

  task automatic new_i_req();
    i_a = $urandom & 32'hffff_fffc;
  endtask

  task automatic new_d_req();
    d_a = $urandom; d_din = $urandom; d_wen = 4'($urandom);
    d_size = 2'($urandom); d_rw = 1'($urandom);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'hBFC00000, 32'h0, 4'h0, 2'b00, 1'b0, 3, 32'h3C1D8000,
                0, 32'hBFC00000, 32'h0, 4'b1111, 2'b10, 1'b0};
    vecs[1] = '{1'b1, 32'h80001004, 32'hDEADBEEF, 4'b0011, 2'b01, 1'b1, 5, 32'h12345678,
                1, 32'h80001004, 32'hDEADBEEF, 4'b0011, 2'b01, 1'b1};
    vecs[2] = '{1'b1, 32'h00000040, 32'h0, 4'b1111, 2'b10, 1'b0, 0, 32'hCAFEF00D,
                1, 32'h00000040, 32'h0, 4'b1111, 2'b10, 1'b0};
    vecs[3] = '{1'b0, 32'h00400010, 32'h0, 4'h0, 2'b00, 1'b0, 0, 32'h8FA20004,
                0, 32'h00400010, 32'h0, 4'b1111, 2'b10, 1'b0};
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    rst = 1'b1; m_ready = 1'b0; m_dout = 32'd0;
    i_strobe = 1'b0; d_strobe = 1'b0; i_a = '0;
    d_a = '0; d_din = 32'd0; d_wen = 4'd0; d_size = 2'd0; d_rw = 1'b0;
    mdl_cnt = 0; mdl_i_dout = 32'd0; mdl_d_dout = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");

    // Both strobes at reset release: D first, then I.
    i_a = 32'h00001000; i_strobe = 1'b1;
    d_a = 32'h00002000; d_din = 32'h0; d_wen = 4'hf; d_size = 2'b10; d_rw = 1'b0; d_strobe = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(1, 32'hAAAA0001);
    chk("simul_first_is_d", obs_gnt, 1);
    d_strobe = 1'b0;
    run_txn(2, 32'hBBBB0002);
    chk("simul_second_is_i", obs_gnt, 0);
    chk("simul_d_dout_kept", d_dout, 32'hAAAA0001);
    i_strobe = 1'b0;

    // Directed vector table.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].is_d) begin
        d_a = vecs[v].a; d_din = vecs[v].din; d_wen = vecs[v].wen;
        d_size = vecs[v].size; d_rw = vecs[v].rw; d_strobe = 1'b1;
      end else begin
        i_a = vecs[v].a; i_strobe = 1'b1;
      end
      run_txn(vecs[v].lat, vecs[v].rdata);
      chk($sformatf("vec%0d_gnt", v), obs_gnt, vecs[v].e_gnt);
      chk($sformatf("vec%0d_m_a", v), obs_a, vecs[v].e_a);
      chk($sformatf("vec%0d_m_din", v), obs_din, vecs[v].e_din);
      chk($sformatf("vec%0d_m_ctl", v), {obs_wen, obs_size, obs_rw},
          {vecs[v].e_wen, vecs[v].e_size, vecs[v].e_rw});
      chk($sformatf("vec%0d_dout", v), obs_dout, vecs[v].rdata);
      i_strobe = 1'b0; d_strobe = 1'b0;
    end

    // Strobe held through RESP is a fresh request granted in the next IDLE cycle.
    i_a = 32'h00000100; i_strobe = 1'b1;
    run_txn(0, 32'h11110000);
    chk("held_first_i", obs_gnt, 0);
    run_txn(0, 32'h22220000);
    chk("held_second_i", obs_gnt, 0);
    i_strobe = 1'b0;

    // Starvation: both sides request continuously.
    new_i_req(); new_d_req(); i_strobe = 1'b1; d_strobe = 1'b1;
    for (int n = 0; n < 10; n++) begin
      run_txn(n % 3, $urandom);
      seq[n] = obs_gnt;
      if (exp_gnt == 1) new_d_req();
      else new_i_req();
    end
    for (int n = 0; n < 10; n++) chk($sformatf("starve_order%0d", n), seq[n], exp_seq[n]);
    i_strobe = 1'b0;
    run_txn(1, $urandom);
    chk("starve_drain_d", obs_gnt, 1);
    d_strobe = 1'b0;

    // Asynchronous reset while BUSY.
    new_d_req(); d_strobe = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    mdl_cnt = 0;
    chk("rst_busy_strobe", {31'd0, m_strobe}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    d_strobe = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mdl_cnt = 0; mdl_i_dout = 32'd0; mdl_d_dout = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
      chk("post_rst_no_strobe", {31'd0, m_strobe}, 32'd0);
    end
    m_ready = 1'b0;
    new_i_req(); i_strobe = 1'b1;
    run_txn(2, 32'h5A5A5A5A);
    chk("post_rst_resume", obs_gnt, 0);
    i_strobe = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 120; n++) begin
      if (!i_strobe && ($urandom % 3 != 0)) begin
        new_i_req(); i_strobe = 1'b1;
      end
      if (!d_strobe && ($urandom % 3 != 0)) begin
        new_d_req(); d_strobe = 1'b1;
      end
      run_txn($urandom % 4, $urandom);
      if (exp_gnt != 2) chk("rand_winner", obs_gnt, exp_gnt);
      if (exp_gnt == 0) i_strobe = 1'b0;
      else if (exp_gnt == 1) d_strobe = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer sharing the single memory-side port between the instruction cache (read-only) and the write-through data cache. It sits between the two caches' miss/write-through ports and the bus bridge. It registers each granted request, holds it stable on the shared port until the bridge's ready, and returns a registered one-cycle ready with the captured read data. Arbitration favours the data side, with a bounded-starvation counter that guarantees instruction fetches progress.

## Interface
Parameters:
- A_WIDTH, 32: address width.
- MAX_D_BURST, 4: consecutive D grants allowed while I is waiting before I is forced (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_a  in  A_WIDTH  instruction fetch address.
- i_strobe  in  1  instruction request valid.
- i_dout  out  32  read data to the instruction cache.
- i_ready  out  1  one-cycle completion pulse to the instruction cache.
- d_a  in  A_WIDTH  data address.
- d_din  in  32  write data from the data cache.
- d_wen  in  4  byte enables.
- d_size  in  2  access size.
- d_rw  in  1  0 = read, 1 = write.
- d_strobe  in  1  data request valid.
- d_dout  out  32  read data to the data cache.
- d_ready  out  1  one-cycle completion pulse to the data cache.
- m_a, m_din, m_wen, m_size, m_rw, m_strobe  out  A_WIDTH/32/4/2/1/1  shared memory-port request.
- m_dout  in  32  memory read data.
- m_ready  in  1  memory completion.

## Operation
- State machine: IDLE, BUSY, RESP. Grant register gnt: 0 = I, 1 = D.
- IDLE arbitration, evaluated each cycle:
  - Neither strobe: stay in IDLE.
  - Only one strobe: grant that requester.
  - Both strobes: grant D, unless wait_cnt == MAX_D_BURST, in which case grant I.
- On grant, latch the request fields into the m_* registers:
  - D grant: d_a, d_din, d_wen, d_size, d_rw.
  - I grant: i_a; m_din=0, m_wen=4'b1111, m_size=2'b10, m_rw=0.
  - Set m_strobe=1 and go to BUSY.
- BUSY: all m_* outputs held stable. When m_ready=1, capture m_dout into i_dout or d_dout (per gnt), clear m_strobe, and go to RESP. Otherwise stay in BUSY.
- RESP: assert the granted side's ready (i_ready or d_ready) for exactly this cycle, then go to IDLE.
- wait_cnt (4 bits):
  - D granted while i_strobe=1: increment, saturating at MAX_D_BURST.
  - I granted: clear to 0.
  - Arbitration in IDLE with i_strobe=0: clear to 0.
- Requester rule: a requester holds its strobe and request fields until it sees its ready. A strobe sampled in the cycle after ready is a new request. The arbiter never re-issues a completed request by itself.
- Data outputs: i_dout and d_dout update only when their own transaction completes; otherwise they hold.
- Write transactions: d_dout captures m_dout anyway; the data cache ignores the value.

## Timing
- Reset values: state IDLE, gnt 0, wait_cnt 0, every m_* output 0, i_ready/d_ready 0, i_dout/d_dout 0.
- Reset mid-transaction: the in-flight request is abandoned and no ready pulse is issued. The bridge is reset by the same rst.
- Latency, with strobe first sampled in IDLE at cycle t:
  - t+1: m_strobe high.
  - First m_ready at cycle k ≥ t+1: ready pulse and valid data at k+1, IDLE at k+2.
  - Minimum request-to-ready: 2 cycles. Back-to-back grant spacing: 3 cycles.
- m_ready is ignored outside BUSY.
- Strobe changes during BUSY/RESP have no effect; they are sampled again in IDLE.
- Both strobes first rising in the same IDLE cycle: D wins (wait_cnt=0). After the D transaction completes, I wins the next IDLE cycle if d_strobe is low.
- Saturation: with MAX_D_BURST=4 and both sides requesting continuously, the grant order is D,D,D,D,I,D,D,D,D,I…

## Test plan
- Single I fetch: i_a=0xBFC00000, i_strobe held, m_ready asserted 3 cycles after m_strobe rises with m_dout=0x3C1D8000. Expected: m_a=0xBFC00000, m_rw=0, m_wen=1111, m_size=10; i_ready one cycle after m_ready with i_dout=0x3C1D8000; d_ready stays 0.
- D write: d_a=0x80001004, d_din=0xDEADBEEF, d_wen=0011, d_size=01, d_rw=1. Expected: m_* carry exactly these values, held stable across 5 wait cycles; d_ready pulses once.
- Simultaneous I and D read strobes at reset release. Expected: D served first, then I; each ready pulses exactly once; i_dout/d_dout each match their own m_dout.
- Starvation, MAX_D_BURST=4: d_strobe re-asserted immediately after every d_ready while i_strobe is held. Expected: I granted as the 5th grant; wait_cnt returns to 0.
- Reset asserted while in BUSY with m_strobe=1. Expected: all outputs read 0 immediately (asynchronously); a subsequent m_ready produces no ready pulse; normal operation resumes after rst falls.
- m_ready high in the same cycle m_strobe first rises. Expected: ready pulse on the next cycle (2-cycle minimum latency); a strobe held through the RESP cycle is treated as a new request.
